// File: rtl/regs_file.sv
// regs_file: 32 x 32-bit RV32I integer register file.
//
//   Two combinational read ports (rs1/rs2) for the decode stage. A write-back
//   to the same nonzero address in the same cycle is forwarded straight to the
//   read port. x0 always reads as zero, and writes to x0 are dropped silently.
//
//   Optional debug access port, enabled with `define REGS_DBG_PORT_EN. It uses
//   a 4-phase req/ack handshake for external register reads and writes. When
//   the macro is undefined, the debug ports stay in the port list, their
//   inputs are ignored, and dbg_ack_o/dbg_rdata_o are tied to zero.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   rs1_addr_i / rs1_data_o   read port 1 (combinational)
//   rs2_addr_i / rs2_data_o   read port 2 (combinational)
//   reg_wen_i, reg_waddr_i,
//   reg_wdata_i               write-back from execute (1-cycle write latency)
//   dbg_req_i, dbg_we_i,
//   dbg_addr_i, dbg_wdata_i   debug request; fields are sampled with req
//   dbg_ack_o                 one-cycle acknowledge pulse
//   dbg_rdata_o               debug read data; held until the next accepted request
module regs_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              reg_wen_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [4:0]        dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] mem [REG_NUM];

    logic              core_we;
    logic              dbg_wr_fire;
    logic [4:0]        dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;

    assign core_we = reg_wen_i && (reg_waddr_i != 5'd0);

    // Shared read selection: x0 is forced to zero, and a same-cycle core
    // write-back to the addressed register overrides the stored value.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [4:0]        waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == 5'd0)
            return '0;
        else if (wen && (waddr == addr))
            return wdata;
        else
            return stored;
    endfunction

    assign rs1_data_o = read_sel(rs1_addr_i, mem[rs1_addr_i], reg_wen_i, reg_waddr_i, reg_wdata_i);
    assign rs2_data_o = read_sel(rs2_addr_i, mem[rs2_addr_i], reg_wen_i, reg_waddr_i, reg_wdata_i);

`ifdef REGS_DBG_PORT_EN
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    logic [1:0]        state;
    logic              cap_we;
    logic [4:0]        cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= 5'd0;
            cap_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req_i) begin
                        cap_we    <= dbg_we_i;
                        cap_addr  <= dbg_addr_i;
                        cap_wdata <= dbg_wdata_i;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!cap_we) begin
                        // Reads see a core write landing in this same cycle.
                        rdata_q <= read_sel(cap_addr, mem[cap_addr],
                                            reg_wen_i, reg_waddr_i, reg_wdata_i);
                        state   <= ST_ACK;
                    end else if (!reg_wen_i) begin
                        // Writes wait for a cycle with no core write-back,
                        // so the core always wins the single write port.
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_WAIT_LOW;
                end
                default: begin
                    // A request held high is not re-accepted until it drops.
                    if (!dbg_req_i)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_wr_fire = (state == ST_ACCESS) && cap_we && !reg_wen_i && (cap_addr != 5'd0);
    assign dbg_wr_addr = cap_addr;
    assign dbg_wr_data = cap_wdata;
    assign dbg_ack_o   = (state == ST_ACK);
    assign dbg_rdata_o = rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg  = ^{dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i};
    assign dbg_wr_fire = 1'b0;
    assign dbg_wr_addr = 5'd0;
    assign dbg_wr_data = '0;
    assign dbg_ack_o   = 1'b0;
    assign dbg_rdata_o = '0;
`endif

    // The core and debug writes are mutually exclusive by construction:
    // a debug write only fires when reg_wen_i is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++)
                mem[i] <= '0;
        end else begin
            if (core_we)
                mem[reg_waddr_i] <= reg_wdata_i;
            if (dbg_wr_fire)
                mem[dbg_wr_addr] <= dbg_wr_data;
        end
    end

endmodule

// File: tb/tb_regs_file.sv
// Testbench for regs_file: a cycle-level scoreboard driven by a reference
// model of the architectural register contents.
module tb_regs_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    regs_file dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
        .reg_wen_i   (reg_wen),
        .reg_waddr_i (reg_waddr),
        .reg_wdata_i (reg_wdata),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eack;
        logic [31:0] erd;
        int          cyc;
    } item_t;

    item_t       sb[$];
    logic [31:0] model [32];
    logic [31:0] exp_rd;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc_no = 0;

    // Architectural view of a read: x0 is zero, same-cycle write-back forwards.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (reg_wen && reg_waddr == a) return reg_wdata;
        return model[a];
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, expv);
    endtask

    // One clock cycle: record what the outputs must show with the current
    // inputs, then advance the model to its state after the edge.
    task automatic tick(input logic eack);
        item_t it;
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            exp_rd = 32'h0;
        end
        it.e1   = model_read(rs1_addr);
        it.e2   = model_read(rs2_addr);
        it.eack = eack;
        it.erd  = exp_rd;
        it.cyc  = cyc_no;
        sb.push_back(it);
        if (!rst && reg_wen && reg_waddr != 5'd0) model[reg_waddr] = reg_wdata;
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT outputs on the falling edge against the scoreboard.
    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check("rs1_data", it.cyc, rs1_data, it.e1);
            check("rs2_data", it.cyc, rs2_data, it.e2);
            check("dbg_ack", it.cyc, {31'b0, dbg_ack}, {31'b0, it.eack});
            check("dbg_rdata", it.cyc, dbg_rdata, it.erd);
        end
    end

    initial begin
        rst = 1'b1;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        reg_wen = 1'b0; reg_waddr = 5'd0; reg_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;
        exp_rd = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            rs1_addr = 5'($urandom_range(31)); rs2_addr = 5'($urandom_range(31));
            tick(1'b0);
        end
        rst = 1'b0;

        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
            tick(1'b0);
        end

        // A write to x0 is discarded.
        reg_wen = 1'b1; reg_waddr = 5'd0; reg_wdata = 32'hDEADBEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick(1'b0);
        reg_wen = 1'b0;
        tick(1'b0);

        // Same-cycle bypass on both ports, then the stored value.
        reg_wen = 1'b1; reg_waddr = 5'd5; reg_wdata = 32'h12345678;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        tick(1'b0);
        reg_wen = 1'b0;
        tick(1'b0);

`ifdef REGS_DBG_PORT_EN
        // Debug read of x7: ack two cycles after req, data held after req falls.
        reg_wen = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'hA5A5A5A5;
        tick(1'b0);
        reg_wen = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        tick(1'b0);
        tick(1'b0);
        exp_rd = 32'hA5A5A5A5;
        tick(1'b1);
        dbg_req = 1'b0;
        tick(1'b0);
        tick(1'b0);

        // Debug write x3 stalled by three cycles of core writes to x3.
        rs1_addr = 5'd3; rs2_addr = 5'd7;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h55;
        tick(1'b0);
        reg_wen = 1'b1; reg_waddr = 5'd3; reg_wdata = 32'h11;
        for (int i = 0; i < 3; i++) tick(1'b0);
        reg_wen = 1'b0;
        tick(1'b0);
        model[3] = 32'h55;
        tick(1'b1);
        dbg_req = 1'b0;
        tick(1'b0);
        tick(1'b0);

        // Request held high after ack produces only one ack.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        tick(1'b0);
        tick(1'b0);
        exp_rd = 32'h55;
        tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        dbg_req = 1'b0;
        tick(1'b0);
        dbg_req = 1'b1; dbg_addr = 5'd5;
        tick(1'b0);
        tick(1'b0);
        exp_rd = 32'h12345678;
        tick(1'b1);
        dbg_req = 1'b0;
        tick(1'b0);

        // Debug read picks up a core write landing in its access cycle.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
        tick(1'b0);
        reg_wen = 1'b1; reg_waddr = 5'd10; reg_wdata = 32'h0BADCAFE;
        tick(1'b0);
        reg_wen = 1'b0;
        exp_rd = 32'h0BADCAFE;
        tick(1'b1);
        dbg_req = 1'b0;
        tick(1'b0);

        // Reset while in ACCESS: no ack, state cleared, next request completes.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
        tick(1'b0);
        rst = 1'b1; dbg_req = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd3;
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reg_wen = 1'b1; reg_waddr = 5'd9; reg_wdata = 32'hCAFEF00D;
        tick(1'b0);
        reg_wen = 1'b0;
        dbg_req = 1'b1; dbg_addr = 5'd9;
        tick(1'b0);
        tick(1'b0);
        exp_rd = 32'hCAFEF00D;
        tick(1'b1);
        dbg_req = 1'b0;
        tick(1'b0);
`endif

        // Randomized core traffic; debug request stays idle when the port is built.
        for (int n = 0; n < 400; n++) begin
            reg_wen   = 1'($urandom_range(1));
            reg_waddr = 5'($urandom_range(31));
            reg_wdata = $urandom;
            rs1_addr  = ($urandom_range(3) == 0) ? reg_waddr : 5'($urandom_range(31));
            rs2_addr  = ($urandom_range(3) == 0) ? reg_waddr : 5'($urandom_range(31));
`ifdef REGS_DBG_PORT_EN
            dbg_req   = 1'b0;
`else
            dbg_req   = 1'($urandom_range(1));
`endif
            dbg_we    = 1'($urandom_range(1));
            dbg_addr  = 5'($urandom_range(31));
            dbg_wdata = $urandom;
            tick(1'b0);
        end
        reg_wen = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
